core_seq_ctrl: RTL



---
 rtl/core_seq_ctrl_pkg.sv | 48 ++++
 rtl/core_seq_ctrl_addr_gen.sv | 63 ++++++
 rtl/core_seq_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the core instruction sequencer: inst word bit map,
// idle word, sequencer states and a packed view of the instruction word.
package core_pkg;

  localparam int INST_W        = 35;
  localparam int INST_A_W      = 11;
  localparam int INST_ACC      = 33;
  localparam int INST_CEN_PMEM = 32;
  localparam int INST_WEN_PMEM = 31;
  localparam int INST_A_PMEM   = 20;
  localparam int INST_CEN_XMEM = 19;
  localparam int INST_WEN_XMEM = 18;
  localparam int INST_A_XMEM   = 7;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXECUTE  = 1;
  localparam int INST_LOAD     = 0;

  localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

  // Field order mirrors the bit positions above, MSB first.
  typedef struct packed {
    logic                rsvd;
    logic                acc;
    logic                cen_pmem;
    logic                wen_pmem;
    logic [INST_A_W-1:0] a_pmem;
    logic                cen_xmem;
    logic                wen_xmem;
    logic [INST_A_W-1:0] a_xmem;
    logic                ofifo_rd;
    logic                ififo_wr;
    logic                ififo_rd;
    logic                l0_rd;
    logic                l0_wr;
    logic                execute;
    logic                load;
  } inst_t;

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_PE, S_GAP, S_A_L0, S_EXEC,
    S_O_WAIT, S_O_RD, S_ACC, S_ACC_CLR, S_DONE
  } state_t;

endpackage

// File: rtl/core_seq_ctrl_addr_gen.sv
// Accumulation-pass pmem address generator: walks output positions and kernel
// taps with incremental counters so no divide or modulo is needed.
module core_seq_addr_gen
  import core_pkg::*;
#(
  parameter int IN_W   = 6,
  parameter int K      = 3,
  parameter int PBASE  = 0,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              tap_next,
  input  logic              out_next,
  output logic [ADDR_W-1:0] addr
);

  localparam int LEN_NIJ = IN_W * IN_W;
  localparam int O_W     = IN_W - K + 1;
  localparam int CW      = $clog2(IN_W + 1);

  logic [ADDR_W-1:0] out_base;
  logic [ADDR_W-1:0] tap_off;
  logic [CW-1:0]     ocol;
  logic [CW-1:0]     kj;

  // out_base = orow*IN_W + ocol; tap_off = kij*LEN_NIJ + ki*IN_W + kj
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_base <= '0;
      tap_off  <= '0;
      ocol     <= '0;
      kj       <= '0;
    end else if (clr) begin
      out_base <= '0;
      tap_off  <= '0;
      ocol     <= '0;
      kj       <= '0;
    end else if (out_next) begin
      tap_off <= '0;
      kj      <= '0;
      if (int'(ocol) == O_W - 1) begin
        ocol     <= '0;
        out_base <= out_base + ADDR_W'(K);
      end else begin
        ocol     <= ocol + 1'b1;
        out_base <= out_base + 1'b1;
      end
    end else if (tap_next) begin
      if (int'(kj) == K - 1) begin
        kj      <= '0;
        tap_off <= tap_off + ADDR_W'(LEN_NIJ + IN_W - K + 1);
      end else begin
        kj      <= kj + 1'b1;
        tap_off <= tap_off + ADDR_W'(LEN_NIJ + 1);
      end
    end
  end

  assign addr = ADDR_W'(PBASE) + out_base + tap_off;

endmodule

// File: rtl/core_seq_ctrl.sv
// Autonomous convolution sequencer driving the systolic core inst word.
// Optional CORE_SEQ_PERF_CNT_EN adds cyc_cnt/stall_cnt performance counters.
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int IN_W    = 6,
  parameter int K       = 3,
  parameter int GAP_CYC = 10,
  parameter int WBASE   = 1024,
  parameter int PBASE   = 0,
  parameter int ADDR_W  = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [34:0] inst,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  output logic [$clog2((IN_W-K+1)*(IN_W-K+1))-1:0] out_idx
`ifdef CORE_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_KIJ  = K * K;
  localparam int O_W      = IN_W - K + 1;
  localparam int LEN_ONIJ = O_W * O_W;
  localparam int OI_W     = $clog2(LEN_ONIJ);
  localparam int KIJ_W    = $clog2(LEN_KIJ + 1);

  if (longint'(PBASE) + longint'(LEN_KIJ) * LEN_NIJ > (longint'(1) << ADDR_W)) begin : g_pmem_range_err
    $error("core_seq_ctrl: psum region exceeds pmem address space");
  end
  if (longint'(WBASE) + longint'(LEN_KIJ) * COL > (longint'(1) << ADDR_W)) begin : g_xmem_range_err
    $error("core_seq_ctrl: weight region exceeds xmem address space");
  end

  state_t            state;
  logic [15:0]       t;
  logic [KIJ_W-1:0]  kij;
  logic [OI_W-1:0]   o;
  logic              last;
  logic              start_ok;
  logic [ADDR_W-1:0] acc_addr;
  inst_t             w;

  function automatic logic [INST_A_W-1:0] a11(input int v);
    return INST_A_W'(ADDR_W'(v));
  endfunction

  assign start_ok = (state == S_IDLE) && start;

  core_seq_addr_gen #(
    .IN_W(IN_W), .K(K), .PBASE(PBASE), .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_ok),
    .tap_next(state == S_ACC && int'(t) < LEN_KIJ),
    .out_next(state == S_ACC_CLR),
    .addr    (acc_addr)
  );

  always_comb begin
    last = 1'b1;
    case (state)
      S_W_L0:         last = int'(t) == COL;
      S_W_PE:         last = int'(t) == COL - 1;
      S_GAP:          last = int'(t) == GAP_CYC;
      S_A_L0, S_O_RD: last = int'(t) == LEN_NIJ;
      S_EXEC:         last = int'(t) == LEN_NIJ + ROW + COL - 1;
      S_ACC:          last = int'(t) == LEN_KIJ + 1;
      default:        last = 1'b1;
    endcase
  end

  // Instruction for the current state cycle; registered into inst below.
  always_comb begin
    w = inst_t'(INST_IDLE);
    case (state)
      S_W_L0: begin
        w.cen_xmem = 1'b0;
        w.a_xmem   = a11(WBASE + int'(kij) * COL + int'(t));
        w.l0_wr    = (t != '0);
      end
      S_W_PE: begin
        w.l0_rd = 1'b1;
        w.load  = 1'b1;
      end
      S_A_L0: begin
        w.cen_xmem = 1'b0;
        w.a_xmem   = a11(int'(t));
        w.l0_wr    = (t != '0);
      end
      S_EXEC: begin
        w.execute = int'(t) < LEN_NIJ;
        w.l0_rd   = int'(t) < LEN_NIJ;
      end
      S_O_RD: begin
        w.ofifo_rd = 1'b1;
        if (t != '0) begin
          w.cen_pmem = 1'b0;
          w.wen_pmem = 1'b0;
          w.a_pmem   = a11(PBASE + int'(kij) * LEN_NIJ + int'(t) - 1);
        end
      end
      S_ACC: begin
        if (int'(t) < LEN_KIJ) begin
          w.cen_pmem = 1'b0;
          w.a_pmem   = a11(int'(acc_addr));
        end
        w.acc = (t != '0) && (int'(t) <= LEN_KIJ);
      end
      default: w = inst_t'(INST_IDLE);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      t         <= '0;
      kij       <= '0;
      o         <= '0;
      inst      <= INST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      inst      <= w;
      done      <= 1'b0;
      out_valid <= 1'b0;
      t         <= last ? '0 : t + 1'b1;
      case (state)
        S_IDLE: if (start) begin
          state <= S_W_L0;
          kij   <= '0;
          o     <= '0;
          busy  <= 1'b1;
        end
        S_W_L0:   if (last) state <= S_W_PE;
        S_W_PE:   if (last) state <= S_GAP;
        S_GAP:    if (last) state <= S_A_L0;
        S_A_L0:   if (last) state <= S_EXEC;
        S_EXEC:   if (last) state <= S_O_WAIT;
        S_O_WAIT: if (ofifo_valid) state <= S_O_RD;
        S_O_RD: if (last) begin
          if (int'(kij) == LEN_KIJ - 1) begin
            state <= S_ACC;
          end else begin
            kij   <= kij + 1'b1;
            state <= S_W_L0;
          end
        end
        S_ACC: if (last) begin
          out_valid <= 1'b1;
          out_idx   <= o;
          state     <= S_ACC_CLR;
        end
        S_ACC_CLR: begin
          if (int'(o) == LEN_ONIJ - 1) begin
            state <= S_DONE;
          end else begin
            o     <= o + 1'b1;
            state <= S_ACC;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CORE_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else if (start_ok) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
      if (state == S_O_WAIT && !ofifo_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
